// File: rtl/irq_program_sequencer_if.sv
// Control strobes, interrupt lines and sequencer status for irq_program_sequencer.
// slave is the sequencer side; master is the side driving it (core or bench).
interface irq_program_sequencer_if #(
   parameter int ADDR_W      = 8,
   parameter int JADDR_W     = 4,
   parameter int NUM_IRQ     = 4,
   parameter int STACK_DEPTH = 4
);
   localparam int DW = $clog2(STACK_DEPTH + 1);

   // Every input is a level that is sampled on each rising clock edge. There is no
   // valid/ready pair: a strobe held for one cycle acts exactly once.
   logic                jmp;
   logic                jmp_nz;
   logic                dont_jmp;
   logic [JADDR_W-1:0]  jmp_addr;
   logic                rti;
   logic                irq_en;
   logic [NUM_IRQ-1:0]  irq_req;
   logic [ADDR_W-1:0]   pm_addr;
   logic [ADDR_W-1:0]   pc;
   logic [NUM_IRQ-1:0]  irq_ack;
   logic [DW-1:0]       depth;
   logic                stack_err;
   logic [NUM_IRQ-1:0]  pending;

   modport master (
      output jmp, jmp_nz, dont_jmp, jmp_addr, rti, irq_en, irq_req,
      input  pm_addr, pc, irq_ack, depth, stack_err, pending
   );

   modport slave (
      input  jmp, jmp_nz, dont_jmp, jmp_addr, rti, irq_en, irq_req,
      output pm_addr, pc, irq_ack, depth, stack_err, pending
   );
endinterface

// File: rtl/irq_program_sequencer.sv
// Program counter sequencer with jumps, edge-triggered vectored interrupts and a return stack.
// Optional macro IRQ_NEST_EN allows nested interrupts; without it only one ISR level is taken.
module irq_program_sequencer #(
   parameter int               ADDR_W      = 8,
   parameter int               JADDR_W     = 4,
   parameter int               NUM_IRQ     = 4,
   parameter int               STACK_DEPTH = 4,
   parameter logic [ADDR_W-1:0] VEC_BASE   = 8'h70
) (
   input  logic                   clk,
   input  logic                   sync_reset,
   irq_program_sequencer_if.slave bus
);
   localparam int             DW        = $clog2(STACK_DEPTH + 1);
   localparam int             IW        = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
   localparam int             SLOTS     = 2 ** DW;
   localparam logic [DW-1:0]  DEPTH_MAX = DW'(STACK_DEPTH);

   logic [ADDR_W-1:0]  pc_q, pc_d;
   logic [NUM_IRQ-1:0] pending_q, pending_d;
   logic [NUM_IRQ-1:0] req_q, req_d;
   logic [DW-1:0]      depth_q, depth_d;
   logic               stack_err_q, stack_err_d;
   // Sized to the full index range of depth so any depth value is a legal index.
   logic [ADDR_W-1:0]  stack_q [SLOTS];
   logic [ADDR_W-1:0]  stack_d [SLOTS];

   logic [NUM_IRQ-1:0] pend_all;
   logic [NUM_IRQ-1:0] ack;
   logic [IW-1:0]      irq_idx;
   logic               nest_ok;
   logic               take;
   logic               rti_pop;
   logic               rti_err;
   logic [ADDR_W-1:0]  natural_next;
   logic [ADDR_W-1:0]  vec_addr;
   logic [ADDR_W-1:0]  pm_addr;

   always_comb begin
      natural_next = pc_q + ADDR_W'(1);
      if (bus.jmp || (bus.jmp_nz && !bus.dont_jmp))
         natural_next = {bus.jmp_addr, {(ADDR_W-JADDR_W){1'b0}}};

      // A request rising this cycle is visible to the take logic immediately.
      pend_all = pending_q | (bus.irq_req & ~req_q);

      irq_idx = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--)
         if (pend_all[i]) irq_idx = IW'(i);

`ifdef IRQ_NEST_EN
      nest_ok = 1'b1;
`else
      nest_ok = (depth_q == '0);
`endif

      take    = !sync_reset && (|pend_all) && bus.irq_en && !bus.rti &&
                (depth_q < DEPTH_MAX) && nest_ok;
      rti_pop = !sync_reset && bus.rti && (depth_q != '0);
      rti_err = !sync_reset && bus.rti && (depth_q == '0);
      ack     = take ? (NUM_IRQ'(1) << irq_idx) : '0;
      vec_addr = VEC_BASE + (ADDR_W'(irq_idx) << 2);

      if (sync_reset)   pm_addr = '0;
      else if (rti_pop) pm_addr = stack_q[depth_q - DW'(1)];
      else if (take)    pm_addr = vec_addr;
      else              pm_addr = natural_next;

      stack_d = stack_q;
      depth_d = depth_q;
      if (take) begin
         stack_d[depth_q] = natural_next;
         depth_d          = depth_q + DW'(1);
      end else if (rti_pop) begin
         depth_d = depth_q - DW'(1);
      end

      pc_d        = pm_addr;
      pending_d   = pend_all & ~ack;
      req_d       = bus.irq_req;
      stack_err_d = stack_err_q | rti_err;
   end

   always_ff @(posedge clk) begin
      if (sync_reset) begin
         pc_q        <= '0;
         pending_q   <= '0;
         req_q       <= '0;
         depth_q     <= '0;
         stack_err_q <= 1'b0;
      end else begin
         pc_q        <= pc_d;
         pending_q   <= pending_d;
         req_q       <= req_d;
         depth_q     <= depth_d;
         stack_err_q <= stack_err_d;
      end
      stack_q <= stack_d;
   end

   assign bus.pm_addr   = pm_addr;
   assign bus.pc        = pc_q;
   assign bus.irq_ack   = ack;
   assign bus.depth     = depth_q;
   assign bus.stack_err = stack_err_q;
   assign bus.pending   = pending_q;
endmodule
